// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite scheduler.
//   NUM_SLOTS / SLOT_W   : number of sprite copies and the width of a slot index
//   SPRITE_W / SPRITE_H  : bitmap size in pixels
//   COORD_W              : raster coordinate width
//   ROM_LAT              : image ROM read latency in cycles
//   slot_t               : per-slot record {x, y, en}
//   meta_t               : per-pixel metadata carried alongside the ROM read
//   state_t              : commit sequencer states
package sprite_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = $clog2(NUM_SLOTS);
  localparam int SPRITE_W  = 48;
  localparam int SPRITE_H  = 48;
  localparam int COORD_W   = 10;
  localparam int ROM_LAT   = 1;

  // Out-of-range ROM address: the bitmap returns black here.
  localparam logic [COORD_W-1:0] ROM_X_NONE = COORD_W'(SPRITE_W);
  localparam logic [COORD_W-1:0] ROM_Y_NONE = COORD_W'(SPRITE_H);

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               en;
  } slot_t;

  typedef struct packed {
    logic              valid;
    logic              hit;
    logic [SLOT_W-1:0] slot;
  } meta_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } state_t;

  // True when p lies in [start, start+len). The end point is formed one bit
  // wider than the coordinate so a sprite near the right/bottom edge clips
  // instead of wrapping round to coordinate 0.
  function automatic logic in_span(input logic [COORD_W-1:0] p,
                                   input logic [COORD_W-1:0] start,
                                   input int                 len);
    logic [COORD_W:0] span_end;
    span_end = {1'b0, start} + (COORD_W+1)'(len);
    return (p >= start) && ({1'b0, p} < span_end);
  endfunction

endpackage

// File: rtl/sprite_slot_match.sv
// Combinational hit test for one sprite slot.
//   sx, sy, en   : active slot position (top-left) and enable
//   pix_x, pix_y : raster coordinate under test
//   hit          : pixel covered by this slot's sprite
//   loc_x, loc_y : sprite-local coordinate (meaningful only when hit=1)
module sprite_slot_match
  import sprite_pkg::*;
(
  input  logic [COORD_W-1:0] sx,
  input  logic [COORD_W-1:0] sy,
  input  logic               en,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  output logic               hit,
  output logic [COORD_W-1:0] loc_x,
  output logic [COORD_W-1:0] loc_y
);

  assign hit = en && in_span(pix_x, sx, SPRITE_W) && in_span(pix_y, sy, SPRITE_H);

  // Wraps when the pixel is outside the sprite; the scheduler discards the
  // value in that case.
  assign loc_x = pix_x - sx;
  assign loc_y = pix_y - sy;

endmodule

// File: rtl/sprite_scheduler.sv
// Places up to NUM_SLOTS copies of one 48x48 bitmap on the raster, all
// sharing a single image ROM.
//
// Ports:
//   clk, rst                 pixel clock, asynchronous active-high reset
//   cfg_valid/cfg_ready      config write handshake
//   cfg_slot, cfg_x, cfg_y,
//   cfg_en                   slot index, top-left position, enable
//   frame_start              one-cycle vsync pulse (display is blanked)
//   pix_valid, pix_x, pix_y  raster coordinate stream, one per cycle
//   rom_x, rom_y             sprite-local address to the image ROM
//   rom_r, rom_g, rom_b      ROM data, ROM_LAT cycles after the address
//   out_valid, out_hit,
//   out_slot, out_r/g/b      composited pixel, 2+ROM_LAT cycles after input
//
// Config handshake: a write transfers on a rising clk edge where
// cfg_valid & cfg_ready are both 1; cfg_slot/x/y/en must be stable while
// cfg_valid is high. cfg_ready is registered and is low only while a commit
// is copying the pending registers, so the producer may hold cfg_valid and
// simply wait. Writes land in pending registers and become visible only
// after the next frame_start commit.
module sprite_scheduler
  import sprite_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [SLOT_W-1:0]  cfg_slot,
  input  logic [COORD_W-1:0] cfg_x,
  input  logic [COORD_W-1:0] cfg_y,
  input  logic               cfg_en,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  output logic [COORD_W-1:0] rom_x,
  output logic [COORD_W-1:0] rom_y,
  input  logic [7:0]         rom_r,
  input  logic [7:0]         rom_g,
  input  logic [7:0]         rom_b,
  output logic               out_valid,
  output logic               out_hit,
  output logic [SLOT_W-1:0]  out_slot,
  output logic [7:0]         out_r,
  output logic [7:0]         out_g,
  output logic [7:0]         out_b
);

  // ---------------------------------------------------------------------
  // Slot registers and commit sequencer
  // ---------------------------------------------------------------------
  slot_t             pend [NUM_SLOTS];
  slot_t             act  [NUM_SLOTS];
  state_t            state;
  logic [SLOT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cfg_ready <= 1'b1;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        pend[i] <= '0;
        act[i]  <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          // A write on the frame_start cycle lands in pending at this same
          // edge, so the commit that follows picks it up.
          if (cfg_valid && cfg_ready) begin
            pend[cfg_slot] <= '{x: cfg_x, y: cfg_y, en: cfg_en};
          end
          if (frame_start) begin
            state     <= ST_COMMIT;
            cnt       <= '0;
            cfg_ready <= 1'b0;
          end
        end
        ST_COMMIT: begin
          // One slot per cycle; frame_start is ignored until done.
          act[cnt] <= pend[cnt];
          cnt      <= cnt + 1'b1;
          if (cnt == SLOT_W'(NUM_SLOTS - 1)) begin
            state     <= ST_IDLE;
            cfg_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Stage 0: per-slot hit test and lowest-index priority select
  // ---------------------------------------------------------------------
  logic [NUM_SLOTS-1:0] hit_vec;
  logic [COORD_W-1:0]   loc_x [NUM_SLOTS];
  logic [COORD_W-1:0]   loc_y [NUM_SLOTS];

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_match
    sprite_slot_match u_match (
      .sx    (act[g].x),
      .sy    (act[g].y),
      .en    (act[g].en),
      .pix_x (pix_x),
      .pix_y (pix_y),
      .hit   (hit_vec[g]),
      .loc_x (loc_x[g]),
      .loc_y (loc_y[g])
    );
  end

  logic               sel_hit;
  logic [SLOT_W-1:0]  sel_slot;
  logic [COORD_W-1:0] sel_x;
  logic [COORD_W-1:0] sel_y;

  // Scanning from the highest index down leaves the lowest hitting slot.
  always_comb begin
    sel_hit  = 1'b0;
    sel_slot = '0;
    sel_x    = ROM_X_NONE;
    sel_y    = ROM_Y_NONE;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        sel_hit  = 1'b1;
        sel_slot = SLOT_W'(i);
        sel_x    = loc_x[i];
        sel_y    = loc_y[i];
      end
    end
  end

  logic s0_hit;
  assign s0_hit = pix_valid && sel_hit;

  // ---------------------------------------------------------------------
  // Stage 1: ROM address plus metadata, then ROM_LAT alignment delay
  // ---------------------------------------------------------------------
  meta_t s1_meta;
  meta_t dly [ROM_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_x   <= ROM_X_NONE;
      rom_y   <= ROM_Y_NONE;
      s1_meta <= '0;
    end else begin
      rom_x   <= s0_hit ? sel_x : ROM_X_NONE;
      rom_y   <= s0_hit ? sel_y : ROM_Y_NONE;
      s1_meta <= '{valid: pix_valid, hit: s0_hit, slot: s0_hit ? sel_slot : '0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROM_LAT; i++) dly[i] <= '0;
    end else begin
      dly[0] <= s1_meta;
      for (int i = 1; i < ROM_LAT; i++) dly[i] <= dly[i-1];
    end
  end

  // ---------------------------------------------------------------------
  // Output register: ROM data is now aligned with its metadata
  // ---------------------------------------------------------------------
  meta_t d_meta;
  assign d_meta = dly[ROM_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_slot  <= '0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
    end else begin
      out_valid <= d_meta.valid;
      out_hit   <= d_meta.hit;
      out_slot  <= d_meta.slot;
      out_r     <= d_meta.hit ? rom_r : 8'd0;
      out_g     <= d_meta.hit ? rom_g : 8'd0;
      out_b     <= d_meta.hit ? rom_b : 8'd0;
    end
  end

endmodule

// File: doc/sprite_scheduler.md
Name: sprite_scheduler

Overview:
- Places up to NUM_SLOTS copies of the 48x48 bitmap sprite on the VGA raster. All copies share the single image ROM (the bitmap loader, which is indexed by x/y and returns registered RGB).
- Per display pixel: hit-tests the active slots, translates screen coordinates into sprite-local ROM coordinates, and re-aligns hit/slot metadata with the ROM's read latency.
- Slot positions are written through a valid/ready config port into pending registers. A sequenced commit copies them to the active registers at frame start, so there is no mid-frame tearing.

Parameters:
- NUM_SLOTS, 4, number of sprite slots (power of 2; SLOT_W = log2(NUM_SLOTS))
- SPRITE_W, 48, sprite width in pixels
- SPRITE_H, 48, sprite height in pixels
- COORD_W, 10, display coordinate width
- ROM_LAT, 1, image ROM read latency in cycles

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when cfg_valid & cfg_ready
- cfg_slot  in  SLOT_W  slot index to write
- cfg_x  in  COORD_W  sprite top-left x
- cfg_y  in  COORD_W  sprite top-left y
- cfg_en  in  1  slot enable
- frame_start  in  1  one-cycle pulse at vsync; display is in blanking
- pix_valid  in  1  pixel coordinate valid
- pix_x  in  COORD_W  raster x
- pix_y  in  COORD_W  raster y
- rom_x  out  COORD_W  sprite-local x to image ROM
- rom_y  out  COORD_W  sprite-local y to image ROM
- rom_r, rom_g, rom_b  in  8 each  ROM pixel data, ROM_LAT cycles after rom_x/rom_y
- out_valid  out  1  output pixel valid
- out_hit  out  1  pixel covered by a sprite
- out_slot  out  SLOT_W  winning slot (0 when no hit)
- out_r, out_g, out_b  out  8 each  output colour

Behaviour:
- Reset (async, rst=1):
  - pending and active slot registers cleared (x=y=0, en=0); FSM to IDLE; any commit in progress is aborted.
  - Pipeline valid/hit flags = 0; rom_x=SPRITE_W, rom_y=SPRITE_H; out_* = 0; cfg_ready=1.
- FSM, states IDLE and COMMIT:
  - IDLE: cfg_ready=1. An accepted write updates pending[cfg_slot] at the clock edge. frame_start=1 -> COMMIT, commit counter=0.
  - COMMIT: cfg_ready=0. Each cycle, active[cnt] <= pending[cnt] and cnt++. After slot NUM_SLOTS-1 is copied -> IDLE. Duration is exactly NUM_SLOTS cycles.
  - frame_start while in COMMIT is ignored.
  - A write accepted in the same cycle as frame_start (IDLE) is included in that commit.
  - Repeated writes to one slot before a commit: last write wins.
- Hit test (combinational, stage 0), slot i:
  - hit_i = active.en & pix_x >= sx & pix_x < sx+SPRITE_W & pix_y >= sy & pix_y < sy+SPRITE_H.
  - The sums use COORD_W+1 bits, so sprites near the 1023 edge clip and never wrap.
  - Priority: lowest slot index wins.
- Stage 1 (registered, cycle t+1):
  - On hit: rom_x = pix_x - sx, rom_y = pix_y - sy.
  - On miss or pix_valid=0: rom_x=SPRITE_W, rom_y=SPRITE_H, an out-of-range address for which the ROM returns black.
  - valid, hit and slot are registered alongside the ROM address.
- Metadata delay: valid/hit/slot are delayed ROM_LAT further cycles in a shift register.
- Output register:
  - out_valid, out_hit and out_slot follow the delayed metadata.
  - out_rgb = rom_rgb if hit, else 0.
  - Total latency pix_valid -> out_valid = 2+ROM_LAT cycles (3 by default), fully pipelined, one pixel per cycle.
  - out_valid tracks pix_valid whether or not the pixel hits.
- Pixels presented during COMMIT see each slot switch on its copy cycle. This is legal only because COMMIT occurs in blanking.

Decomposition:
- Package sprite_pkg: SPRITE_W, SPRITE_H, COORD_W, NUM_SLOTS, SLOT_W, and a slot record type {x, y, en}.
- Sub-module sprite_slot_match: one instance per slot. Performs the combinational bounds test and the local-coordinate subtraction.
- The priority select, FSM and pipeline stay in sprite_scheduler.

Test Plan:
- Reset then stream pixels (10,10) and (100,100) with no config -> out_valid 3 cycles later, out_hit=0, out_rgb=0, rom_x=48, rom_y=48.
- Write slot0 (x=100, y=50, en=1) then frame_start; pixel (100,50) -> rom_x=0, rom_y=0 one cycle later; pixel (147,97) -> (47,47); pixel (148,97) -> miss.
- Write slot0 and slot1 at the same position, both enabled, then commit; pixel inside -> out_slot=0. Disable slot0 and commit -> out_slot=1.
- cfg_valid held high across frame_start -> cfg_ready low for exactly 4 cycles. A write coincident with frame_start is active after the commit. A write without a subsequent frame_start is not visible.
- Slot at x=1000 -> pixel (1023,y) hits with rom_x=23; pixel x=0 does not hit (no wrap).
- Assert rst mid-COMMIT with pixels in flight -> outputs 0 immediately, cfg_ready=1, all slots disabled afterwards.
